// File: rtl/mem_io_bridge.sv
// mem_io_bridge: decodes the CPU data-memory port into data RAM and a small
// memory-mapped I/O block (TX character FIFO, STATUS, CYCLES).
//
// I/O map (byte offsets from IO_BASE):
//   +0x0 TXDATA  write pushes WriteData[7:0]; reads as 0
//   +0x4 STATUS  {21'b0, empty, full, ovf, count[7:0]}; write bit 8 = 1 clears ovf
//   +0x8 CYCLES  free-running cycle counter (0 when the counter is compiled out)
//   +0xC reserved, reads as 0
//
// Build option: define MEM_IO_BRIDGE_CYCLE_COUNTER_EN to include the 32-bit
// cycle counter. Without it no counter flops exist and CYCLES reads 0.
//
// TX drain handshake: a character moves when tx_valid && tx_ready are both high
// at a rising clk edge; tx_valid/tx_data depend only on registered state, and
// tx_valid stays high with tx_data stable until that transfer happens.
module mem_io_bridge #(
  parameter int          N          = 13,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] IO_BASE    = 32'h0001_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   Addr,
  input  logic [31:0]   WriteData,
  input  logic          MemWrite,
  output logic [31:0]   ReadData,
  output logic [N-1:0]  ram_addr,
  output logic [31:0]   ram_wdata,
  output logic          ram_we,
  input  logic [31:0]   ram_rdata,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // FIFO state; storage is intentionally left out of reset
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic        w_ram_sel;
  logic        w_io_sel;
  logic        w_tx_sel;
  logic        w_status_sel;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;
  logic        w_ovf_clr;
  logic [31:0] w_cycles;
  logic [31:0] w_status;

  // Region decode; anything neither below IO_BASE nor inside the 16-byte block is unmapped
  assign w_ram_sel    = (Addr < IO_BASE);
  assign w_io_sel     = (Addr[31:4] == IO_BASE[31:4]);
  assign w_tx_sel     = w_io_sel && (Addr[3:2] == 2'd0);
  assign w_status_sel = w_io_sel && (Addr[3:2] == 2'd1);

  assign ram_addr  = Addr[N+1:2];
  assign ram_wdata = WriteData;
  assign ram_we    = MemWrite & w_ram_sel;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // A push into a full FIFO is still accepted when a pop frees a slot the same edge
  assign w_pop     = tx_valid & tx_ready;
  assign w_push    = MemWrite & w_tx_sel & (~w_full | w_pop);
  assign w_drop    = MemWrite & w_tx_sel & w_full & ~w_pop;
  assign w_ovf_clr = MemWrite & w_status_sel & WriteData[8];

  assign tx_valid = ~w_empty;
  assign tx_data  = r_mem[r_rd_ptr];

  assign w_status = {21'b0, w_empty, w_full, r_ovf, 8'(r_count)};

  // FIFO pointers, occupancy and sticky overflow; a drop beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  // Character storage write port
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= WriteData[7:0];
  end

`ifdef MEM_IO_BRIDGE_CYCLE_COUNTER_EN
  logic [31:0] r_cycles;

  // Free-running cycle counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cycles <= '0;
    else     r_cycles <= r_cycles + 32'd1;
  end

  assign w_cycles = r_cycles;
`else
  assign w_cycles = 32'h0;
`endif

  // Zero-latency load mux; reads never change state
  always_comb begin
    ReadData = 32'h0;
    if (w_ram_sel) begin
      ReadData = ram_rdata;
    end else if (w_io_sel) begin
      case (Addr[3:2])
        2'd1:    ReadData = w_status;
        2'd2:    ReadData = w_cycles;
        default: ReadData = 32'h0;
      endcase
    end
  end

endmodule
